// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states and byte/halfword/word write strobes.
// Define AHB_SRAM_ERR_EN to build the legality checks and the two-cycle ERROR response.
module ahb_sram_slave #(
   parameter int ADDR_WIDTH  = 16,
   parameter int MEM_DEPTH   = 16384,
   parameter int WAIT_STATES = 1
) (
   input  logic                  hclk,
   input  logic                  hreset,
   input  logic                  hsel_i,
   input  logic                  hready_i,
   input  logic [1:0]            htrans_i,
   input  logic [2:0]            hsize_i,
   input  logic                  hwrite_i,
   input  logic [ADDR_WIDTH-1:0] haddr_i,
   input  logic [31:0]           hwdata_i,
   output logic                  hready_o,
   output logic [1:0]            hresp_o,
   output logic [31:0]           hrdata_o
);

   localparam int         IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

`ifdef AHB_SRAM_ERR_EN
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_e;
`else
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LAST} state_e;
`endif

   state_e             state_q;
   logic [3:0]         cnt_q;
   logic               write_q;
   logic [3:0]         strb_q;
   logic [IDX_W-1:0]   idx_q;
   logic               hready_q;
   logic [1:0]         hresp_q;

   logic               accept;
   logic [3:0]         strb_d;
   logic [IDX_W-1:0]   idx_d;
   logic               illegal;

   logic [31:0]        mem [MEM_DEPTH];

   assign accept = hsel_i & hready_i & htrans_i[1];
   assign idx_d  = haddr_i[IDX_W+1:2];

   // Sizes above word fall into the default arm; with checks on they are rejected anyway.
   always_comb begin
      strb_d = 4'b0000;
      case (hsize_i)
         3'b000:  strb_d = 4'b0001 << haddr_i[1:0];
         3'b001:  strb_d = haddr_i[1] ? 4'b1100 : 4'b0011;
         default: strb_d = 4'b1111;
      endcase
   end

`ifdef AHB_SRAM_ERR_EN
   logic [31:0] word_idx;
   assign word_idx = 32'(haddr_i[ADDR_WIDTH-1:2]);
   assign illegal  = (hsize_i > 3'b010)
                   | ((hsize_i == 3'b001) & haddr_i[0])
                   | ((hsize_i == 3'b010) & (haddr_i[1:0] != 2'b00))
                   | (word_idx >= 32'(MEM_DEPTH));
`else
   // Without checks the upper address bits simply wrap onto the array.
   logic unused_addr;
   assign unused_addr = ^haddr_i;
   assign illegal     = 1'b0;
`endif

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         write_q  <= 1'b0;
         strb_q   <= 4'b0000;
         idx_q    <= '0;
         hready_q <= 1'b1;
         hresp_q  <= RESP_OKAY;
      end else begin
         case (state_q)
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q  <= S_LAST;
                  hready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
`ifdef AHB_SRAM_ERR_EN
            S_ERR1: begin
               state_q  <= S_ERR2;
               hready_q <= 1'b1;
               hresp_q  <= RESP_ERROR;
            end
`endif
            default: begin
               // IDLE, LAST and ERR2 all have hready_o high and may take a new address phase.
               hready_q <= 1'b1;
               hresp_q  <= RESP_OKAY;
               state_q  <= S_IDLE;
               if (accept) begin
                  write_q <= hwrite_i;
                  strb_q  <= strb_d;
                  idx_q   <= idx_d;
`ifdef AHB_SRAM_ERR_EN
                  if (illegal) begin
                     state_q  <= S_ERR1;
                     hready_q <= 1'b0;
                     hresp_q  <= RESP_ERROR;
                  end else
`endif
                  if (WAIT_STATES > 0) begin
                     state_q  <= S_WAIT;
                     cnt_q    <= CNT_LOAD;
                     hready_q <= 1'b0;
                  end else begin
                     state_q  <= S_LAST;
                  end
               end
            end
         endcase
      end
   end

   // A reset landing on the committing edge discards the pending write.
   always_ff @(posedge hclk) begin
      if (!hreset && (state_q == S_LAST) && write_q) begin
         for (int b = 0; b < 4; b++) begin
            if (strb_q[b]) mem[idx_q][8*b +: 8] <= hwdata_i[8*b +: 8];
         end
      end
   end

   assign hready_o = hready_q;
   assign hrdata_o = (state_q == S_LAST) ? mem[idx_q] : 32'd0;
`ifdef AHB_SRAM_ERR_EN
   assign hresp_o  = hresp_q;
`else
   logic unused_resp;
   assign unused_resp = ^{hresp_q, illegal};
   assign hresp_o     = RESP_OKAY;
`endif

endmodule
